adder_latch_display: RTL

Parametrised successor to the 1-bit adder/carry-latch LED demo. Adds two WIDTH-bit operands with carry-in and registers the result. Keeps sticky carry and signed-overflow latches plus a saturating carry-event counter. Drives a run/stop prescaled tick counter and a mode-selected LED bus. Sits between PMOD inputs and the board LEDs; clk is the 12 MHz board clock.

---
 rtl/adder_latch_display_pkg.sv | 16 +
 rtl/adder_latch_display_tick_prescaler.sv | 44 ++++
 rtl/adder_latch_display.sv | 124 ++++++++++++
 3 files changed

// File: rtl/adder_latch_display_pkg.sv
// rtl/adder_latch_display_pkg.sv - shared LED mode encodings and board timing constants
package adder_latch_display_pkg;

    // LED bus display selections
    typedef enum logic [1:0] {
        MODE_SUM   = 2'd0,
        MODE_FLAGS = 2'd1,
        MODE_TICK  = 2'd2,
        MODE_BLINK = 2'd3
    } led_mode_e;

    // Board clock and the default half-second tick derived from it
    localparam int unsigned CLK_HZ           = 12_000_000;
    localparam int unsigned DEFAULT_PRESCALE = CLK_HZ / 2;

endpackage

// File: rtl/adder_latch_display_tick_prescaler.sv
// rtl/adder_latch_display_tick_prescaler.sv - run/stop prescaled tick, tick counter and blink toggle
module tick_prescaler
    import adder_latch_display_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE,
    parameter int unsigned CNT_W    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic             tick,
    output logic [CNT_W-1:0] tick_cnt,
    output logic             blink
);

    localparam int unsigned     PS_W = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q;
    logic            wrap;

    // A wrap only happens while running, so pausing can never manufacture a tick
    assign wrap = run && (ps_q == LAST);

    // Prescaler holds its count while stopped so a resumed period is not restarted
    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q     <= '0;
            tick     <= 1'b0;
            tick_cnt <= '0;
            blink    <= 1'b0;
        end else begin
            tick <= wrap;
            if (run) begin
                ps_q <= wrap ? '0 : ps_q + 1'b1;
            end
            if (wrap) begin
                tick_cnt <= tick_cnt + 1'b1;
                blink    <= ~blink;
            end
        end
    end

endmodule

// File: rtl/adder_latch_display.sv
// rtl/adder_latch_display.sv - registered adder with sticky carry/overflow latches and LED display
module adder_latch_display
    import adder_latch_display_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned EVT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             clr_latch,
    input  logic [1:0]       mode,
    output logic [WIDTH:0]   led,
    output logic [WIDTH:0]   sum,
    output logic             carry_latched,
    output logic             ovf_latched,
    output logic             tick,
    output logic [CNT_W-1:0] tick_cnt,
    output logic [EVT_W-1:0] evt_cnt
);

    localparam int unsigned LW = WIDTH + 1;
    // Number of flag / tick-count bits that actually fit on the LED bus
    localparam int unsigned FW = (LW < 3) ? LW : 3;
    localparam int unsigned TW = (CNT_W < LW) ? CNT_W : LW;

    localparam logic [EVT_W-1:0] EVT_MAX = '1;

    logic [WIDTH:0] sum_q;
    logic           a_sign_q;
    logic           b_sign_q;
    logic           carry_w;
    logic           ovf_w;
    logic           carry_prev_q;
    logic           carry_edge;
    logic           blink;
    logic [2:0]     flags;

    // Widen before adding so the carry lands in the top bit of the result
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q    <= '0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
        end else begin
            sum_q    <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            a_sign_q <= a[WIDTH-1];
            b_sign_q <= b[WIDTH-1];
        end
    end

    assign carry_w = sum_q[WIDTH];
    // Signed overflow: like-signed operands producing an opposite-signed result
    assign ovf_w   = (a_sign_q == b_sign_q) && (sum_q[WIDTH-1] != a_sign_q);

    // Sticky latches; a new event beats a simultaneous clear so nothing is lost
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_latched <= 1'b0;
            ovf_latched   <= 1'b0;
        end else begin
            if (carry_w) begin
                carry_latched <= 1'b1;
            end else if (clr_latch) begin
                carry_latched <= 1'b0;
            end
            if (ovf_w) begin
                ovf_latched <= 1'b1;
            end else if (clr_latch) begin
                ovf_latched <= 1'b0;
            end
        end
    end

    assign carry_edge = carry_w && !carry_prev_q;

    // Count carry rising edges, saturating; a clear coinciding with an edge leaves 1
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_prev_q <= 1'b0;
            evt_cnt      <= '0;
        end else begin
            carry_prev_q <= carry_w;
            if (clr_latch) begin
                evt_cnt <= carry_edge ? EVT_W'(1) : '0;
            end else if (carry_edge && (evt_cnt != EVT_MAX)) begin
                evt_cnt <= evt_cnt + 1'b1;
            end
        end
    end

    tick_prescaler #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_tick_prescaler (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .tick     (tick),
        .tick_cnt (tick_cnt),
        .blink    (blink)
    );

    assign sum   = sum_q;
    assign flags = {(evt_cnt != '0), ovf_latched, carry_latched};

    // LED source select; unused upper bits stay zero
    always_comb begin
        led = '0;
        case (led_mode_e'(mode))
            MODE_SUM:   led = sum_q;
            MODE_FLAGS: led[FW-1:0] = flags[FW-1:0];
            MODE_TICK:  led[TW-1:0] = tick_cnt[TW-1:0];
            MODE_BLINK: led = {LW{carry_latched & blink}};
            default:    led = '0;
        endcase
    end

endmodule
